// File: rtl/cv32e40p_apu_trace_buffer.sv
// Multi-channel capture buffer for APU register-file writebacks: timestamps,
// class-filters and queues events in a show-ahead FIFO drained over valid/ready.

module cv32e40p_apu_trace_lane (
  input  logic       valid_i,
  input  logic       enable_i,
  input  logic [1:0] filter_i,
  input  logic       fp_i,
  output logic       elig_o
);
  logic w_class_ok;

  always_comb begin
    w_class_ok = 1'b0;
    case (filter_i)
      2'b00:   w_class_ok = 1'b1;
      2'b01:   w_class_ok = !fp_i;
      2'b10:   w_class_ok = fp_i;
      default: w_class_ok = 1'b0;
    endcase
  end

  assign elig_o = valid_i & enable_i & w_class_ok;
endmodule

module cv32e40p_apu_trace_buffer #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [1:0]                   filter_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_waddr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_result_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [CHW-1:0]               rd_ch_o,
  output logic [ADDR_WIDTH-1:0]        rd_waddr_o,
  output logic [DATA_WIDTH-1:0]        rd_result_o,
  output logic [TS_WIDTH-1:0]          rd_ts_o,
  output logic [CW-1:0]                count_o,
  output logic [15:0]                  drop_cnt_o,
  output logic                         overflow_o
);
  logic [CHW-1:0]        r_mem_ch    [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_waddr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_res   [DEPTH];
  logic [TS_WIDTH-1:0]   r_mem_ts    [DEPTH];

  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [TS_WIDTH-1:0] r_ts;
  logic [15:0]         r_drop;
  logic                r_ovf;

  logic [NUM_CH-1:0]         w_elig, w_store;
  logic [AW-1:0]             w_idx [NUM_CH];
  logic [CW-1:0]             w_free, w_k, w_pushed, w_dropped;
  logic                      w_valid, w_pop;
  logic [16:0]               w_drop_sum;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      cv32e40p_apu_trace_lane u_lane (
        .valid_i  (ch_valid_i[g]),
        .enable_i (enable_i),
        .filter_i (filter_i),
        .fp_i     (ch_waddr_i[g*ADDR_WIDTH+5]),
        .elig_o   (w_elig[g])
      );
    end
  endgenerate

  // Free space is taken before this cycle's pop, so a same-cycle pop never
  // makes room; eligible events are ranked low channel first.
  always_comb begin
    w_free    = CW'(DEPTH) - r_count;
    w_k       = '0;
    w_pushed  = '0;
    w_dropped = '0;
    w_store   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_idx[c] = r_wr_ptr + AW'(w_k);
      if (w_elig[c]) begin
        if (w_k < w_free) begin
          w_store[c] = 1'b1;
          w_pushed   = w_pushed + CW'(1);
        end else begin
          w_dropped  = w_dropped + CW'(1);
        end
        w_k = w_k + CW'(1);
      end
    end
  end

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & rd_ready_i;
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_dropped);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ts     <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ts     <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (enable_i) r_ts <= r_ts + TS_WIDTH'(1);
      r_wr_ptr <= r_wr_ptr + AW'(w_pushed);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + w_pushed - CW'(w_pop);
      if (w_dropped != '0) begin
        r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        r_ovf  <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_store[c]) begin
          r_mem_ch[w_idx[c]]    <= CHW'(c);
          r_mem_waddr[w_idx[c]] <= ch_waddr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
          r_mem_res[w_idx[c]]   <= ch_result_i[c*DATA_WIDTH +: DATA_WIDTH];
          r_mem_ts[w_idx[c]]    <= r_ts;
        end
      end
    end
  end

  assign rd_valid_o  = w_valid;
  assign rd_ch_o     = w_valid ? r_mem_ch[r_rd_ptr]    : '0;
  assign rd_waddr_o  = w_valid ? r_mem_waddr[r_rd_ptr] : '0;
  assign rd_result_o = w_valid ? r_mem_res[r_rd_ptr]   : '0;
  assign rd_ts_o     = w_valid ? r_mem_ts[r_rd_ptr]    : '0;
  assign count_o     = r_count;
  assign drop_cnt_o  = r_drop;
  assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_cv32e40p_apu_trace_buffer.sv
// Directed bench for the APU trace buffer: filtering, ordering, overflow,
// push/pop interplay, stall stability, pointer wrap, clear and async reset.

module tb_cv32e40p_apu_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, enable, clear, rd_ready;
  logic [1:0]  filter, ch_valid;
  logic [11:0] ch_waddr;
  logic [63:0] ch_result;
  logic        rd_valid, rd_ch, overflow;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_result, rd_ts;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  int unsigned nres;

  cv32e40p_apu_trace_buffer dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .filter_i(filter), .ch_valid_i(ch_valid), .ch_waddr_i(ch_waddr),
    .ch_result_i(ch_result), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_ch_o(rd_ch), .rd_waddr_o(rd_waddr), .rd_result_o(rd_result),
    .rd_ts_o(rd_ts), .count_o(count), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [5:0] a0, input logic [31:0] r0,
                       input logic [5:0] a1, input logic [31:0] r1);
    ch_valid  = v;
    ch_waddr  = {a1, a0};
    ch_result = {r1, r0};
  endtask

  // One cycle against the reference queue (filter all, enable on).
  task automatic cyc(input logic [1:0] v, input logic r);
    int k, free;
    logic [31:0] r0, r1;
    r0 = 32'h5000 + nres; r1 = r0 + 32'd1; nres += 2;
    drive(v, 6'h03, r0, 6'h23, r1);
    rd_ready = r;
    chk("sb_count", count, q.size());
    chk("sb_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) chk("sb_data", rd_result, q[0]);
    free = DEPTH - q.size();
    if (r && q.size() != 0) void'(q.pop_front());
    k = 0;
    if (v[0]) begin if (k < free) q.push_back(r0); k++; end
    if (v[1]) begin if (k < free) q.push_back(r1); k++; end
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; filter = 2'b00; rd_ready = 1'b0;
    drive(2'b00, 6'h0, 32'h0, 6'h0, 32'h0);
    step(); step();
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ts", rd_ts, 0);
    rst = 1'b0;

    // basic capture at ts=3
    enable = 1'b1;
    step(); step(); step();
    drive(2'b01, 6'h05, 32'hDEADBEEF, 6'h00, 32'h0); rd_ready = 1'b1;
    step();
    drive(2'b00, 6'h0, 32'h0, 6'h0, 32'h0);
    chk("t1_valid", rd_valid, 1);
    chk("t1_ch", rd_ch, 0);
    chk("t1_waddr", rd_waddr, 6'h05);
    chk("t1_res", rd_result, 32'hDEADBEEF);
    chk("t1_ts", rd_ts, 3);
    chk("t1_count", count, 1);
    step();
    chk("t1_count_pop", count, 0);
    chk("t1_valid_pop", rd_valid, 0);

    // class filter
    filter = 2'b01; rd_ready = 1'b0;
    drive(2'b11, 6'h21, 32'hAAAA, 6'h02, 32'hBBBB);
    step();
    chk("t2i_count", count, 1);
    chk("t2i_ch", rd_ch, 1);
    chk("t2i_waddr", rd_waddr, 6'h02);
    chk("t2i_res", rd_result, 32'hBBBB);
    chk("t2i_ts", rd_ts, 5);
    ch_valid = 2'b00; rd_ready = 1'b1;
    step();
    filter = 2'b10; rd_ready = 1'b0; ch_valid = 2'b11;
    step();
    chk("t2f_count", count, 1);
    chk("t2f_ch", rd_ch, 0);
    chk("t2f_waddr", rd_waddr, 6'h21);
    ch_valid = 2'b00; rd_ready = 1'b1;
    step();
    filter = 2'b11; rd_ready = 1'b0; ch_valid = 2'b11;
    step();
    chk("t2n_count", count, 0);
    filter = 2'b00;

    // overflow: 9 cycles of two events into 16 slots
    clear = 1'b1; ch_valid = 2'b00;
    step();
    clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(2'b11, 6'(i), 32'h100 + 32'(2*i), 6'h20 | 6'(i), 32'h101 + 32'(2*i));
      step();
    end
    chk("t3_count", count, 16);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_ovf", overflow, 1);
    chk("t3_head_res", rd_result, 32'h100);
    chk("t3_head_ch", rd_ch, 0);
    chk("t3_head_ts", rd_ts, 0);

    // full + pop + push: push still dropped
    drive(2'b01, 6'h01, 32'h0BAD, 6'h0, 32'h0); rd_ready = 1'b1;
    step();
    chk("t4_count", count, 15);
    chk("t4_drop", drop_cnt, 3);
    chk("t4_head_res", rd_result, 32'h101);
    chk("t4_head_ch", rd_ch, 1);
    drive(2'b01, 6'h01, 32'h600D, 6'h0, 32'h0);
    step();
    chk("t4_count15", count, 15);
    chk("t4_drop_hold", drop_cnt, 3);
    ch_valid = 2'b00;
    for (int j = 2; j < 16; j++) begin
      chk("t4_drain_res", rd_result, 32'h100 + 32'(j));
      chk("t4_drain_ts", rd_ts, 32'(j / 2));
      step();
    end
    chk("t4_last_res", rd_result, 32'h600D);
    chk("t4_last_ts", rd_ts, 10);
    step();
    chk("t4_empty", count, 0);

    // stall stability then random fill/drain through the wrap
    nres = 0;
    cyc(2'b01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(2'b01, 1'b0);
      chk("t5_hold_res", rd_result, 32'h5000);
      chk("t5_hold_ch", rd_ch, 0);
      chk("t5_hold_waddr", rd_waddr, 6'h03);
    end
    for (int i = 0; i < 60; i++)
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6));
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc(2'b00, 1'b1);
    chk("t5_drained", q.size(), 0);
    chk("t5_count0", count, 0);

    // clear with count 7 and pushes pending
    cyc(2'b11, 1'b0); cyc(2'b11, 1'b0); cyc(2'b11, 1'b0); cyc(2'b01, 1'b0);
    chk("t6_count7", count, 7);
    clear = 1'b1; ch_valid = 2'b11;
    step();
    clear = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_valid", rd_valid, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_ovf", overflow, 0);
    drive(2'b01, 6'h07, 32'h77, 6'h0, 32'h0);
    step();
    ch_valid = 2'b00;
    chk("t6_ts0", rd_ts, 0);
    chk("t6_valid1", rd_valid, 1);

    // async reset mid-burst
    ch_valid = 2'b11;
    for (int i = 0; i < 9; i++) step();
    chk("t6_ovf_pre", overflow, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", rd_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_res", rd_result, 0);
    chk("ar_ts", rd_ts, 0);
    chk("ar_waddr", rd_waddr, 0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
